draw_character: RTL



---
 rtl/vga_if.sv | 15 +
 rtl/draw_character.sv | 108 ++++++++++
 2 files changed

// File: rtl/vga_if.sv
// VGA pixel-stream bundle: raster position, sync/blank strobes and 12-bit colour.
interface vga_if;
  logic [11:0] hcount;
  logic [11:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport master (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport slave  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport out    (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport in     (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/draw_character.sv
// Overlays the character sprite onto the VGA stream. Position and skin latch once
// per frame. The pipeline is three stages deep and matches the registered sprite ROM.
module draw_character #(
  parameter int          SPRITE_W     = 47,
  parameter int          SPRITE_H     = 63,
  parameter logic [11:0] TRANSPARENT  = 12'hF0F,
  parameter logic [11:0] PLATFORM_RGB = 12'h2B4,
  parameter logic [11:0] PLATFORM_SUB = 12'h2B5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] value_x,
  input  logic [11:0] value_y,
  input  logic [2:0]  character_skin,
  output logic [14:0] rom_addr,
  input  logic [11:0] rom_data,
  vga_if.in           vga_in,
  vga_if.out          vga_out
);

  typedef struct packed {
    logic [11:0] hcount;
    logic [11:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;
  } vga_t;

  logic [11:0] x_q, x_d;
  logic [11:0] y_q, y_d;
  logic [2:0]  skin_q, skin_d;
  logic [14:0] rom_addr_q, rom_addr_d;
  logic        hit1_q, hit1_d;
  logic        hit2_q;
  vga_t        s0, s1_q, s2_q, out_q;
  logic [11:0] rgb_d;
  logic        frame_start;
  logic [12:0] h13, v13, x13, y13;
  logic [5:0]  col, row;

  always_comb begin
    s0 = '{hcount: vga_in.hcount, vcount: vga_in.vcount, hsync: vga_in.hsync,
           vsync: vga_in.vsync, hblnk: vga_in.hblnk, vblnk: vga_in.vblnk,
           rgb: vga_in.rgb};
    frame_start = (vga_in.hcount == '0) && (vga_in.vcount == '0);

    // Pixel (0,0) is evaluated against the values being latched on this same edge.
    x_d    = frame_start ? value_x : x_q;
    y_d    = frame_start ? value_y : y_q;
    skin_d = skin_q;
    if (frame_start) skin_d = (character_skin > 3'd4) ? '0 : character_skin;

    // Widening to 13 bits keeps the far sprite edge from wrapping past 4095.
    h13 = {1'b0, vga_in.hcount};
    v13 = {1'b0, vga_in.vcount};
    x13 = {1'b0, x_d};
    y13 = {1'b0, y_d};
    hit1_d = (h13 >= x13) && (h13 <= x13 + 13'(SPRITE_W - 1)) &&
             (v13 >= y13) && (v13 <= y13 + 13'(SPRITE_H - 1)) &&
             !vga_in.hblnk && !vga_in.vblnk;

    col = vga_in.hcount[5:0] - x_d[5:0];
    row = vga_in.vcount[5:0] - y_d[5:0];
    rom_addr_d = hit1_d ? {skin_d, row, col} : rom_addr_q;

    rgb_d = s2_q.rgb;
    if (hit2_q && rom_data != TRANSPARENT)
      rgb_d = (rom_data == PLATFORM_RGB) ? PLATFORM_SUB : rom_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q        <= '0;
      y_q        <= '0;
      skin_q     <= '0;
      rom_addr_q <= '0;
      hit1_q     <= 1'b0;
      hit2_q     <= 1'b0;
      s1_q       <= '0;
      s2_q       <= '0;
      out_q      <= '0;
    end else begin
      x_q        <= x_d;
      y_q        <= y_d;
      skin_q     <= skin_d;
      rom_addr_q <= rom_addr_d;
      hit1_q     <= hit1_d;
      hit2_q     <= hit1_q;
      s1_q       <= s0;
      s2_q       <= s1_q;
      out_q      <= '{hcount: s2_q.hcount, vcount: s2_q.vcount, hsync: s2_q.hsync,
                      vsync: s2_q.vsync, hblnk: s2_q.hblnk, vblnk: s2_q.vblnk,
                      rgb: rgb_d};
    end
  end

  assign rom_addr       = rom_addr_q;
  assign vga_out.hcount = out_q.hcount;
  assign vga_out.vcount = out_q.vcount;
  assign vga_out.hsync  = out_q.hsync;
  assign vga_out.vsync  = out_q.vsync;
  assign vga_out.hblnk  = out_q.hblnk;
  assign vga_out.vblnk  = out_q.vblnk;
  assign vga_out.rgb    = out_q.rgb;

endmodule
